cpu_bus_responder: RTL
======================

Name: cpu_bus_responder

Overview:
- Responder end of the CPU execution-unit memory bus: decodes CPU address, routes read/write strobes to internal 2 KB work RAM, PPU register port, APU/IO port or cartridge port, and returns read data with the fixed latency the execution FSM expects.
- Owns the $4014 OAM DMA engine: on a CPU write to $4014 it asserts halt, copies 256 bytes from page {wdata,8'h00} to PPU OAMDATA, then releases halt.

Parameters:
- DMA_START_DELAY, 1, cycles between accepted $4014 write and first DMA read (halt already high).
- OAMDATA_REG, 3'd4, PPU register index written by DMA.
- RAM_AW, 11, work-RAM address width; RAM mirrored across $0000-$1FFF.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cpu_addr  in  16  bus address from execution unit
- cpu_wdata  in  8  write data
- cpu_we  in  1  write enable (level; may stay high several cycles)
- cpu_re  in  1  read strobe (one-cycle pulse)
- cpu_rdata  out  8  read data to execution unit
- halt  out  1  stalls execution unit while DMA runs
- ppu_addr  out  3  PPU register index
- ppu_wdata  out  8;  ppu_we  out  1;  ppu_re  out  1;  ppu_rdata  in  8
- io_addr  out  5  offset within $4000-$401F;  io_wdata  out  8;  io_we  out  1;  io_re  out  1;  io_rdata  in  8
- cart_addr  out  16;  cart_wdata  out  8;  cart_we  out  1;  cart_re  out  1;  cart_rdata  in  8
- dma_active  out  1  status/debug, high from trigger to last OAM write

Behaviour:
- Reset (async, rst low): halt=0, dma_active=0, all *_we/*_re=0, cpu_rdata select=RAM, DMA FSM=IDLE, index=0, edge-detect registers cleared. Reset mid-DMA aborts the copy immediately.
- Decode: $0000-$1FFF RAM (addr[RAM_AW-1:0]); $2000-$3FFF PPU (addr[2:0]); $4000-$401F IO, except a write to $4014 goes to DMA, not io_we; $4020-$FFFF cart.
- Strobes forwarded combinationally in the request cycle to exactly one target; targets are synchronous and hold rdata until their next re.
- Read: sel_q registered on the clock edge that samples cpu_re high; cpu_rdata = mux(sel_q) of target rdata; valid from the cycle after the strobe until the next read strobe. No fixed latency beyond 1 cycle.
- Write acceptance: a write is acted on only when cpu_we=1 AND (cpu_we was 0 the previous cycle OR cpu_addr changed). A held cpu_we therefore produces exactly one target write. This prevents a $4014 re-trigger after halt drops.
- DMA FSM: IDLE -> (accepted write to $4014 while IDLE) latch page=cpu_wdata, halt=1, dma_active=1, cnt=0 -> WAIT (DMA_START_DELAY cycles) -> RD: drive read of {page,idx} through the normal decode (RAM/PPU/IO/cart) -> WR: ppu_addr=OAMDATA_REG, ppu_wdata=rdata of selected target, ppu_we=1 -> idx==8'hFF ? DONE : idx+1, RD. DONE: halt=0, dma_active=0, idx=0 -> IDLE.
- Total halt duration = 1 + DMA_START_DELAY + 512 cycles; halt rises the cycle after the accepted write.
- While dma_active: CPU-side strobes are ignored (no forwarding); cpu_rdata select is not updated.
- $4014 write while DMA active: ignored. Reads of $4014 go to the IO port.
- Page $20-$3F DMA source reads PPU register mirror, as hardware does; no special case.

Decomposition:
- Shared package: address-region enum (REG_RAM, REG_PPU, REG_IO, REG_CART), DMA state enum, constants DMA_REG_ADDR=16'h4014, OAMDATA index.
- Sub-module cpu_ram_2k: synchronous single-port 2^RAM_AW x 8 RAM, read data registered and held until next re.

Test Plan:
- Write $0805=8'hA5 (cpu_we held 3 cycles), read $0005 -> one RAM write; cpu_rdata=8'hA5 from cycle after read strobe.
- Read $2002 with ppu_rdata=8'h80; read $3FFA -> ppu_re with ppu_addr=2, then ppu_addr=2 (mirror); cpu_rdata=8'h80.
- Read $C000 (cart_rdata=8'h4C), then $4016 (io_rdata=8'h41) -> cart_re, then io_re with io_addr=5'h16; cpu_rdata 8'h4C then 8'h41.
- RAM $0200-$02FF preloaded with i; write $4014=8'h02 with cpu_we held 10 cycles -> halt high 514 cycles, 256 ppu_we with ppu_addr=4 and data 0..255 in order, then exactly one DMA (no re-trigger).
- During DMA drive cpu_re at $0000 and a write to $4014 -> no RAM/IO strobes, no second DMA, cpu_rdata select unchanged.
- Assert rst at DMA byte 100 -> halt=0, dma_active=0, no further ppu_we; a new $4014 write after reset starts a fresh 256-byte copy from idx 0.

Source files
------------

// File: rtl/cpu_bus_responder_pkg.sv
// rtl/cpu_bus_responder_pkg.sv - shared types and address decode for the CPU bus responder
// Contents: region_t (bus target), dma_state_t (OAM DMA FSM states),
// DMA_REG_ADDR / OAMDATA_IDX constants, decode_region() address decoder.
package cpu_bus_responder_pkg;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_PPU,
        REG_IO,
        REG_CART
    } region_t;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_WAIT,
        DMA_RD,
        DMA_WR,
        DMA_DONE
    } dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;
    localparam logic [2:0]  OAMDATA_IDX  = 3'd4;

    // $0000-$1FFF RAM, $2000-$3FFF PPU, $4000-$401F IO, everything else cart.
    function automatic region_t decode_region(input logic [15:0] addr);
        region_t r;
        if (addr[15:13] == 3'b000) begin
            r = REG_RAM;
        end else if (addr[15:13] == 3'b001) begin
            r = REG_PPU;
        end else if (addr[15:5] == 11'h200) begin
            r = REG_IO;
        end else begin
            r = REG_CART;
        end
        return r;
    endfunction

endpackage

// File: rtl/cpu_ram_2k.sv
// rtl/cpu_ram_2k.sv - synchronous single-port work RAM with registered, held read data
// Ports: clk, rst (async, active-low, clears rdata only), addr[AW-1:0],
// wdata[7:0], we, re, rdata[7:0] (updated on re, held otherwise).
module cpu_ram_2k #(
    parameter int unsigned AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    input  logic          we,
    input  logic          re,
    output logic [7:0]    rdata
);

    logic [7:0] mem [0:(1 << AW) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= 8'h00;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - CPU memory-bus responder with address decode and $4014 OAM DMA
// Ports: clk, rst (async, active-low); cpu_addr/cpu_wdata/cpu_we/cpu_re/cpu_rdata
// from the execution unit; halt and dma_active status; ppu_*, io_* and cart_*
// target ports (addr, wdata, we, re out; rdata in). Work RAM is internal.
module cpu_bus_responder
    import cpu_bus_responder_pkg::*;
#(
    parameter int unsigned DMA_START_DELAY = 1,
    parameter logic [2:0]  OAMDATA_REG     = OAMDATA_IDX,
    parameter int unsigned RAM_AW          = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_rdata,
    output logic        halt,
    output logic [2:0]  ppu_addr,
    output logic [7:0]  ppu_wdata,
    output logic        ppu_we,
    output logic        ppu_re,
    input  logic [7:0]  ppu_rdata,
    output logic [4:0]  io_addr,
    output logic [7:0]  io_wdata,
    output logic        io_we,
    output logic        io_re,
    input  logic [7:0]  io_rdata,
    output logic [15:0] cart_addr,
    output logic [7:0]  cart_wdata,
    output logic        cart_we,
    output logic        cart_re,
    input  logic [7:0]  cart_rdata,
    output logic        dma_active
);

    localparam logic [15:0] WAIT_LAST =
        (DMA_START_DELAY == 0) ? 16'd0 : 16'(DMA_START_DELAY - 1);

    dma_state_t state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    region_t     sel_q;
    region_t     dma_sel_q;
    logic        prev_we_q;
    logic [15:0] prev_addr_q;

    logic        busy;
    logic        cpu_go;
    logic        we_accept;
    logic        dma_trigger;
    region_t     cpu_region;
    region_t     dma_region;
    logic [15:0] dma_addr;
    logic [15:0] bus_addr;
    logic [7:0]  ram_rdata;
    logic        ram_we;
    logic        ram_re;
    logic [7:0]  dma_rdata;

    assign busy       = (state_q != DMA_IDLE);
    assign halt       = busy;
    assign dma_active = busy;
    assign cpu_go     = !busy;

    // The execution unit may hold cpu_we for several cycles; only the first
    // cycle of a write (or a change of address under a held we) is acted on,
    // so a held $4014 write cannot restart the DMA once halt drops.
    assign we_accept   = cpu_we && (!prev_we_q || (cpu_addr != prev_addr_q));
    assign cpu_region  = decode_region(cpu_addr);
    assign dma_trigger = cpu_go && we_accept && (cpu_addr == DMA_REG_ADDR);

    // DMA source reads use the normal decode, so a page in $20-$3F hits the
    // PPU register mirror just like the CPU would.
    assign dma_addr   = {page_q, idx_q};
    assign dma_region = decode_region(dma_addr);
    assign bus_addr   = busy ? dma_addr : cpu_addr;

    assign io_addr    = bus_addr[4:0];
    assign io_wdata   = cpu_wdata;
    assign cart_addr  = bus_addr;
    assign cart_wdata = cpu_wdata;

    cpu_ram_2k #(
        .AW(RAM_AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .addr  (bus_addr[RAM_AW-1:0]),
        .wdata (cpu_wdata),
        .we    (ram_we),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    always_comb begin
        cpu_rdata = ram_rdata;
        case (sel_q)
            REG_PPU:  cpu_rdata = ppu_rdata;
            REG_IO:   cpu_rdata = io_rdata;
            REG_CART: cpu_rdata = cart_rdata;
            default:  cpu_rdata = ram_rdata;
        endcase
    end

    always_comb begin
        dma_rdata = ram_rdata;
        case (dma_sel_q)
            REG_PPU:  dma_rdata = ppu_rdata;
            REG_IO:   dma_rdata = io_rdata;
            REG_CART: dma_rdata = cart_rdata;
            default:  dma_rdata = ram_rdata;
        endcase
    end

    // Strobe routing: DMA owns the bus in RD/WR, the CPU only in IDLE,
    // nobody in WAIT/DONE.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ppu_we    = 1'b0;
        ppu_re    = 1'b0;
        io_we     = 1'b0;
        io_re     = 1'b0;
        cart_we   = 1'b0;
        cart_re   = 1'b0;
        ppu_addr  = bus_addr[2:0];
        ppu_wdata = cpu_wdata;
        if (state_q == DMA_RD) begin
            case (dma_region)
                REG_RAM:  ram_re  = 1'b1;
                REG_PPU:  ppu_re  = 1'b1;
                REG_IO:   io_re   = 1'b1;
                default:  cart_re = 1'b1;
            endcase
        end else if (state_q == DMA_WR) begin
            ppu_addr  = OAMDATA_REG;
            ppu_wdata = dma_rdata;
            ppu_we    = 1'b1;
        end else if (cpu_go) begin
            if (cpu_re) begin
                case (cpu_region)
                    REG_RAM:  ram_re  = 1'b1;
                    REG_PPU:  ppu_re  = 1'b1;
                    REG_IO:   io_re   = 1'b1;
                    default:  cart_re = 1'b1;
                endcase
            end
            if (we_accept) begin
                case (cpu_region)
                    REG_RAM:  ram_we  = 1'b1;
                    REG_PPU:  ppu_we  = 1'b1;
                    REG_IO:   io_we   = (cpu_addr != DMA_REG_ADDR);
                    default:  cart_we = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            DMA_IDLE: begin
                if (dma_trigger) begin
                    page_d  = cpu_wdata;
                    idx_d   = 8'h00;
                    cnt_d   = 16'd0;
                    state_d = (DMA_START_DELAY == 0) ? DMA_RD : DMA_WAIT;
                end
            end
            DMA_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = DMA_RD;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DMA_RD: begin
                state_d = DMA_WR;
            end
            DMA_WR: begin
                if (idx_q == 8'hFF) begin
                    state_d = DMA_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = DMA_RD;
                end
            end
            DMA_DONE: begin
                idx_d   = 8'h00;
                state_d = DMA_IDLE;
            end
            default: begin
                state_d = DMA_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= DMA_IDLE;
            page_q      <= 8'h00;
            idx_q       <= 8'h00;
            cnt_q       <= 16'd0;
            sel_q       <= REG_RAM;
            dma_sel_q   <= REG_RAM;
            prev_we_q   <= 1'b0;
            prev_addr_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            prev_we_q   <= cpu_we;
            prev_addr_q <= cpu_addr;
            if (cpu_go && cpu_re) begin
                sel_q <= cpu_region;
            end
            if (state_q == DMA_RD) begin
                dma_sel_q <= dma_region;
            end
        end
    end

endmodule
